port_out_bank: RTL and testbench
================================

# port_out_bank

Parametrised memory-mapped output port bank: the successor to the fixed 16 × 8-bit output port block. It sits on the CPU data bus beside RAM and the input ports, and decodes writes into N output registers. It adds register read-back, per-port update strobes, and an optional double-buffered mode in which several ports change on the same clock edge through a commit address.

## Interface
- N_PORTS, 16, number of output ports (1..32)
- DATA_W, 8, port and bus data width
- ADDR_W, 8, bus address width
- BASE_ADDR, 8'hE0, address of port 0; port i sits at BASE_ADDR+i
- CTRL_ADDR, 8'hDF, control register address
- COMMIT_ADDR, 8'hDE, commit strobe address
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low
- address  input  ADDR_W  bus address
- data_in  input  DATA_W  bus write data
- write  input  1  write enable, sampled on clock
- read  input  1  read enable, sampled on clock
- data_out  output  DATA_W  registered read data
- read_valid  output  1  data_out valid for this cycle
- port_out  output  N_PORTS*DATA_W  port i at bits [i*DATA_W +: DATA_W]
- updated  output  N_PORTS  one-cycle pulse per port after its output register loads
- pending  output  1  any uncommitted shadow write exists

## Operation
- Per port: output register, shadow register, dirty bit. CTRL register bit 0 = BUF (0 direct, 1 buffered). CTRL bits [DATA_W-1:1] read as 0.
- Reset (asynchronous, reset low): all port_out, shadows, dirty, CTRL, data_out, read_valid and updated = 0; pending = 0.
- Direct mode, write to BASE_ADDR+i: output[i] <= data_in, shadow[i] <= data_in, updated[i] pulses.
- Buffered mode, write to BASE_ADDR+i: shadow[i] <= data_in, dirty[i] <= 1. The output is unchanged and updated does not pulse.
- Write to COMMIT_ADDR (either mode): for every i with dirty[i], output[i] <= shadow[i], updated[i] pulses, dirty[i] <= 0. Ports that are not dirty do not pulse. data_in is ignored.
- Write to CTRL_ADDR: BUF <= data_in[0]. On a 1→0 transition, every shadow[i] <= output[i] and all dirty bits clear. Pending writes are discarded, not committed.
- Read: on a read cycle, data_out <= value and read_valid <= 1 on the next edge. Value is:
  - output[i] for a port address
  - CTRL for CTRL_ADDR
  - 0 for COMMIT_ADDR or any unmapped address
  read_valid is 1 for all read cycles, mapped or not.
- Read and write in the same cycle: the read returns the value from before the write.
- Writes outside the three regions are ignored.
- pending = OR of dirty bits (combinational from registers).
- Address compare is over the full ADDR_W. The port region must not overlap CTRL_ADDR or COMMIT_ADDR, and BASE_ADDR+N_PORTS-1 must be less than 2^ADDR_W. Violating either is an elaboration error.

## Timing
- Write → port_out change: visible after the write edge (0 extra cycles). updated is high for exactly the one cycle following that edge.
- Read latency: 1 cycle. With no read, read_valid is 0 and data_out holds its last value.
- Back-to-back writes to the same port in buffered mode: the last write wins; dirty stays 1.
- Buffered write to port i and a commit in the same cycle cannot occur (single address bus).
- A commit with no dirty ports is a no-op: no pulses.
- Reset asserted mid-operation clears everything immediately, including pending shadows and an in-flight read_valid.

## Structure
- Shared package port_out_pkg holds:
  - default address constants (BASE, CTRL, COMMIT)
  - the CTRL bit index BUF_BIT
- Sub-module port_out_cell (one per port, generate loop). It holds the output register, shadow register and dirty bit, with inputs wr_hit, buf_mode, commit and discard. Its outputs are the port value, dirty and updated.
- The top level holds address decode, the CTRL register, the read-back mux and the data_out/read_valid registers.

## Test plan
- Reset, then direct write 8'hA5 to E3 → port 3 = A5 after the edge; updated = 0x0008 for one cycle; other ports 0.
- Write CTRL=1, then write E0=11 and E5=22 → port_out unchanged and pending=1. Then write DE → ports 0 and 5 update on the same edge, updated = 0x0021, pending=0.
- Buffered write E7=3C, then write CTRL=0 → port 7 stays 00, pending=0. A following commit produces no updated pulse.
- Read E3 in the same cycle as a write of 5A to E3 (old value A5) → next cycle data_out=A5, read_valid=1; a subsequent read returns 5A.
- Read D0 (unmapped) → data_out=00, read_valid=1. Write D0=FF → no port changes.
- Assert reset low between a buffered write and its commit → all outputs, shadows and pending clear asynchronously. A commit after reset release changes nothing.

Source files
------------

// File: rtl/port_out_pkg.sv
// Shared constants for the memory-mapped output port bank.
package port_out_pkg;

  localparam logic [7:0] DEF_BASE_ADDR   = 8'hE0;
  localparam logic [7:0] DEF_CTRL_ADDR   = 8'hDF;
  localparam logic [7:0] DEF_COMMIT_ADDR = 8'hDE;

  localparam int BUF_BIT = 0;

endpackage

// File: rtl/port_out_cell.sv
// One output port: the visible register, its shadow copy and the dirty flag
// that marks a buffered write still waiting for a commit.
module port_out_cell #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_hit_i,
  input  logic              buf_mode_i,
  input  logic              commit_i,
  input  logic              discard_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] port_o,
  output logic              dirty_o,
  output logic              updated_o
);

  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              dirty_q, dirty_d;
  logic              updated_q, updated_d;

  // wr_hit, commit and discard come from distinct addresses, so at most one is set.
  always_comb begin
    out_d     = out_q;
    shadow_d  = shadow_q;
    dirty_d   = dirty_q;
    updated_d = 1'b0;
    if (discard_i) begin
      shadow_d = out_q;
      dirty_d  = 1'b0;
    end else if (wr_hit_i && buf_mode_i) begin
      shadow_d = data_i;
      dirty_d  = 1'b1;
    end else if (wr_hit_i) begin
      out_d     = data_i;
      shadow_d  = data_i;
      updated_d = 1'b1;
    end else if (commit_i && dirty_q) begin
      out_d     = shadow_q;
      dirty_d   = 1'b0;
      updated_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      shadow_q  <= '0;
      dirty_q   <= 1'b0;
      updated_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      shadow_q  <= shadow_d;
      dirty_q   <= dirty_d;
      updated_q <= updated_d;
    end
  end

  assign port_o    = out_q;
  assign dirty_o   = dirty_q;
  assign updated_o = updated_q;

endmodule

// File: rtl/port_out_bank.sv
// Bus-mapped bank of output ports with read-back, update strobes and an
// optional double-buffered mode where a commit write updates ports together.
module port_out_bank
  import port_out_pkg::*;
#(
  parameter int                N_PORTS     = 16,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(DEF_CTRL_ADDR),
  parameter logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(DEF_COMMIT_ADDR)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      write,
  input  logic                      read,
  output logic [DATA_W-1:0]         data_out,
  output logic                      read_valid,
  output logic [N_PORTS*DATA_W-1:0] port_out,
  output logic [N_PORTS-1:0]        updated,
  output logic                      pending
);

  localparam int FIRST_PORT = int'(BASE_ADDR);
  localparam int LAST_PORT  = FIRST_PORT + N_PORTS - 1;

  if (N_PORTS < 1 || N_PORTS > 32) begin : g_err_nports
    $error("port_out_bank: N_PORTS must be 1..32");
  end
  if (LAST_PORT >= (1 << ADDR_W)) begin : g_err_range
    $error("port_out_bank: port region exceeds the address space");
  end
  if (int'(CTRL_ADDR) >= FIRST_PORT && int'(CTRL_ADDR) <= LAST_PORT) begin : g_err_ctrl
    $error("port_out_bank: CTRL_ADDR overlaps the port region");
  end
  if (int'(COMMIT_ADDR) >= FIRST_PORT && int'(COMMIT_ADDR) <= LAST_PORT) begin : g_err_commit
    $error("port_out_bank: COMMIT_ADDR overlaps the port region");
  end

  logic              buf_q;
  logic              read_valid_q;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ctrl_wr, commit_wr, discard;
  logic [N_PORTS-1:0] port_hit;
  logic [N_PORTS-1:0] dirty;
  logic [DATA_W-1:0] port_val [N_PORTS];

  assign ctrl_wr   = write && (address == CTRL_ADDR);
  assign commit_wr = write && (address == COMMIT_ADDR);
  // Leaving buffered mode throws away uncommitted shadows.
  assign discard   = ctrl_wr && buf_q && !data_in[BUF_BIT];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    assign port_hit[i] = (address == ADDR_W'(FIRST_PORT + i));

    port_out_cell #(.DATA_W(DATA_W)) u_cell (
      .clock      (clock),
      .reset      (reset),
      .wr_hit_i   (write && port_hit[i]),
      .buf_mode_i (buf_q),
      .commit_i   (commit_wr),
      .discard_i  (discard),
      .data_i     (data_in),
      .port_o     (port_val[i]),
      .dirty_o    (dirty[i]),
      .updated_o  (updated[i])
    );

    assign port_out[i*DATA_W +: DATA_W] = port_val[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q <= 1'b0;
    end else if (ctrl_wr) begin
      buf_q <= data_in[BUF_BIT];
    end
  end

  always_comb begin
    data_out_d = '0;
    if (address == CTRL_ADDR) begin
      data_out_d = DATA_W'(buf_q);
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (port_hit[i]) begin
        data_out_d = port_val[i];
      end
    end
  end

  // Sampling registered state here gives read-before-write on a shared cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= read;
      if (read) begin
        data_out_q <= data_out_d;
      end
    end
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;
  assign pending    = |dirty;

endmodule

// File: tb/tb_port_out_bank.sv
// Directed vector bench for port_out_bank with the default 16 x 8-bit map.
module tb_port_out_bank;

  logic         clock;
  logic         reset;
  logic [7:0]   address;
  logic [7:0]   data_in;
  logic         write;
  logic         read;
  logic [7:0]   data_out;
  logic         read_valid;
  logic [127:0] port_out;
  logic [15:0]  updated;
  logic         pending;

  int checks = 0;
  int errors = 0;

  port_out_bank dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .data_in    (data_in),
    .write      (write),
    .read       (read),
    .data_out   (data_out),
    .read_valid (read_valid),
    .port_out   (port_out),
    .updated    (updated),
    .pending    (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [7:0]   addr;
    logic [7:0]   din;
    logic [127:0] po;
    logic [15:0]  upd;
    logic         pend;
    logic         rv;
    logic [7:0]   dout;
  } vec_t;

  vec_t vecs [27];

  function automatic logic [127:0] pv(int idx, logic [7:0] v);
    return 128'(v) << (idx * 8);
  endfunction

  function automatic vec_t mk(logic wr, logic rd, logic [7:0] addr, logic [7:0] din,
                              logic [127:0] po, logic [15:0] upd, logic pend,
                              logic rv, logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.din = din;
    v.po = po; v.upd = upd; v.pend = pend; v.rv = rv; v.dout = dout;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic wr, logic rd, logic [7:0] addr, logic [7:0] din);
    write   = wr;
    read    = rd;
    address = addr;
    data_in = din;
  endtask

  task automatic check_all(string tag, logic [127:0] po, logic [15:0] upd,
                           logic pend, logic rv, logic [7:0] dout);
    chk({tag, "_port_out"}, port_out, po);
    chk({tag, "_updated"}, 128'(updated), 128'(upd));
    chk({tag, "_pending"}, 128'(pending), 128'(pend));
    chk({tag, "_read_valid"}, 128'(read_valid), 128'(rv));
    chk({tag, "_data_out"}, 128'(data_out), 128'(dout));
  endtask

  logic [127:0] s0, s1, s2, s3, s4;

  initial begin
    s0 = '0;
    s1 = pv(3, 8'hA5);
    s2 = s1 | pv(0, 8'h11) | pv(5, 8'h22);
    s3 = (s2 & ~pv(3, 8'hFF)) | pv(3, 8'h5A);
    s4 = s3 | pv(15, 8'hC3);

    vecs[0]  = mk(0, 0, 8'h00, 8'h00, s0, 16'h0000, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 8'hE3, 8'hA5, s1, 16'h0008, 0, 0, 8'h00);
    vecs[2]  = mk(0, 0, 8'h00, 8'h00, s1, 16'h0000, 0, 0, 8'h00);
    vecs[3]  = mk(1, 0, 8'hDF, 8'h01, s1, 16'h0000, 0, 0, 8'h00);
    vecs[4]  = mk(1, 0, 8'hE0, 8'h11, s1, 16'h0000, 1, 0, 8'h00);
    vecs[5]  = mk(1, 0, 8'hE5, 8'h22, s1, 16'h0000, 1, 0, 8'h00);
    vecs[6]  = mk(1, 0, 8'hDE, 8'h77, s2, 16'h0021, 0, 0, 8'h00);
    vecs[7]  = mk(0, 0, 8'h00, 8'h00, s2, 16'h0000, 0, 0, 8'h00);
    vecs[8]  = mk(0, 1, 8'hDF, 8'h00, s2, 16'h0000, 0, 1, 8'h01);
    vecs[9]  = mk(1, 0, 8'hE7, 8'h3C, s2, 16'h0000, 1, 0, 8'h01);
    vecs[10] = mk(1, 0, 8'hE7, 8'h4D, s2, 16'h0000, 1, 0, 8'h01);
    vecs[11] = mk(1, 0, 8'hDF, 8'h00, s2, 16'h0000, 0, 0, 8'h01);
    vecs[12] = mk(1, 0, 8'hDE, 8'h00, s2, 16'h0000, 0, 0, 8'h01);
    vecs[13] = mk(0, 1, 8'hE7, 8'h00, s2, 16'h0000, 0, 1, 8'h00);
    vecs[14] = mk(1, 1, 8'hE3, 8'h5A, s3, 16'h0008, 0, 1, 8'hA5);
    vecs[15] = mk(0, 1, 8'hE3, 8'h00, s3, 16'h0000, 0, 1, 8'h5A);
    vecs[16] = mk(0, 1, 8'hDE, 8'h00, s3, 16'h0000, 0, 1, 8'h00);
    vecs[17] = mk(0, 1, 8'hE5, 8'h00, s3, 16'h0000, 0, 1, 8'h22);
    vecs[18] = mk(0, 1, 8'hD0, 8'h00, s3, 16'h0000, 0, 1, 8'h00);
    vecs[19] = mk(1, 0, 8'hD0, 8'hFF, s3, 16'h0000, 0, 0, 8'h00);
    vecs[20] = mk(0, 1, 8'hDF, 8'h00, s3, 16'h0000, 0, 1, 8'h00);
    vecs[21] = mk(1, 0, 8'hEF, 8'hC3, s4, 16'h8000, 0, 0, 8'h00);
    vecs[22] = mk(1, 0, 8'hF0, 8'h99, s4, 16'h0000, 0, 0, 8'h00);
    vecs[23] = mk(0, 1, 8'hEF, 8'h00, s4, 16'h0000, 0, 1, 8'hC3);
    vecs[24] = mk(0, 1, 8'hF0, 8'h00, s4, 16'h0000, 0, 1, 8'h00);
    vecs[25] = mk(1, 0, 8'hDF, 8'hFF, s4, 16'h0000, 0, 0, 8'h00);
    vecs[26] = mk(0, 1, 8'hDF, 8'h00, s4, 16'h0000, 0, 1, 8'h01);

    reset = 1'b0;
    drive(0, 0, 8'h00, 8'h00);
    #1;
    check_all("reset", s0, 16'h0000, 0, 0, 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge clock);
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
      @(posedge clock);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].po, vecs[i].upd, vecs[i].pend,
                vecs[i].rv, vecs[i].dout);
    end

    // Buffered write left pending, then reset hits while a read is in flight.
    @(negedge clock);
    drive(1, 0, 8'hE2, 8'h66);
    @(posedge clock);
    #1;
    check_all("buf_e2", s4, 16'h0000, 1, 0, 8'h01);

    @(negedge clock);
    drive(0, 1, 8'hE3, 8'h00);
    @(posedge clock);
    #1;
    check_all("pre_rst_rd", s4, 16'h0000, 1, 1, 8'h5A);
    #1;
    reset = 1'b0;
    #1;
    check_all("async_rst", s0, 16'h0000, 0, 0, 8'h00);

    @(negedge clock);
    drive(0, 0, 8'h00, 8'h00);
    reset = 1'b1;

    @(negedge clock);
    drive(1, 0, 8'hDE, 8'h00);
    @(posedge clock);
    #1;
    check_all("commit_after_rst", s0, 16'h0000, 0, 0, 8'h00);

    @(negedge clock);
    drive(0, 1, 8'hDF, 8'h00);
    @(posedge clock);
    #1;
    check_all("ctrl_after_rst", s0, 16'h0000, 0, 1, 8'h00);

    @(negedge clock);
    drive(1, 0, 8'hE2, 8'h66);
    @(posedge clock);
    #1;
    check_all("direct_after_rst", pv(2, 8'h66), 16'h0004, 0, 0, 8'h00);

    @(negedge clock);
    drive(0, 0, 8'h00, 8'h00);
    @(posedge clock);
    #1;
    check_all("pulse_end", pv(2, 8'h66), 16'h0000, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
